// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator driving an external single-bit comparator.
// Stops at the first unequal bit pair and holds the result until the next accepted start.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       bit_a,
    output logic                       bit_b,
    input  logic                       bit_gt,
    input  logic                       bit_eq,
    input  logic                       bit_lt,
    output logic                       busy,
    output logic                       done,
    output logic                       gt,
    output logic                       eq,
    output logic                       lt,
    output logic                       err,
    output logic [$clog2(WIDTH):0]     nbits
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned NB_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   sh_a_q;
    logic [WIDTH-1:0]   sh_b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NB_W-1:0]    nbits_q;
    logic               busy_q;
    logic               done_q;
    logic               gt_q;
    logic               eq_q;
    logic               lt_q;
    logic               err_q;
    logic               onehot_c;

    // Comparator response is trusted only when exactly one flag is set.
    assign onehot_c = ( bit_gt & ~bit_eq & ~bit_lt) |
                      (~bit_gt &  bit_eq & ~bit_lt) |
                      (~bit_gt & ~bit_eq &  bit_lt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            idx_q   <= '0;
            nbits_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_a_q  <= a_in;
                        sh_b_q  <= b_in;
                        idx_q   <= IDX_W'(WIDTH - 1);
                        nbits_q <= '0;
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    nbits_q <= nbits_q + NB_W'(1);
                    if (!onehot_c) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (bit_gt) begin
                        gt_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (bit_lt) begin
                        lt_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (idx_q == '0) begin
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        sh_a_q <= {sh_a_q[WIDTH-2:0], 1'b0};
                        sh_b_q <= {sh_b_q[WIDTH-2:0], 1'b0};
                        idx_q  <= idx_q - IDX_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Current bit pair goes straight from the shift registers to the bit comparator.
    assign bit_a = (state_q == COMPARE) & sh_a_q[WIDTH-1];
    assign bit_b = (state_q == COMPARE) & sh_b_q[WIDTH-1];

    assign busy  = busy_q;
    assign done  = done_q;
    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign err   = err_q;
    assign nbits = nbits_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: behavioural single-bit comparator plus
// an arithmetic reference for result, nbits and done latency.
module tb_serial_magnitude_comparator;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bit_a;
    logic         bit_b;
    logic         bit_gt;
    logic         bit_eq;
    logic         bit_lt;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;
    logic         err;
    logic [3:0]   nbits;

    logic         force_en;
    logic [2:0]   force_val;

    int           total;
    int           passed;

    always #5 clk = ~clk;

    // Single-bit comparator, with an override used to inject bad responses.
    assign bit_gt = force_en ? force_val[2] : ( bit_a & ~bit_b);
    assign bit_eq = force_en ? force_val[1] : ( bit_a ==  bit_b);
    assign bit_lt = force_en ? force_val[0] : (~bit_a &  bit_b);

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .bit_a  (bit_a),
        .bit_b  (bit_b),
        .bit_gt (bit_gt),
        .bit_eq (bit_eq),
        .bit_lt (bit_lt),
        .busy   (busy),
        .done   (done),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .err    (err),
        .nbits  (nbits)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pairs examined = WIDTH minus the index of the highest differing bit.
    function automatic int ref_nbits(input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        x = int'(a ^ b);
        if (x == 0) return W;
        return W + 1 - $clog2(x + 1);
    endfunction

    // One operation; optional ignored start in inj_cyc and forced 3'b101 in force_cyc.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_cyc, input int force_cyc);
        int  exp_nb;
        logic [3:0] exp_res;
        logic [3:0] res_seen;
        logic [3:0] nb_seen;
        bit  got;
        if (force_cyc > 0) begin
            exp_nb  = force_cyc;
            exp_res = 4'b0001;
        end else begin
            exp_nb  = ref_nbits(a, b);
            exp_res = {a > b, a == b, a < b, 1'b0};
        end
        got = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == inj_cyc + 1) start = 1'b0;
            if (c == force_cyc + 1) force_en = 1'b0;
            if (c == 1) begin
                chk("busy_c1", 32'(busy), 32'd1);
                chk("bits_c1", 32'({bit_a, bit_b}), 32'({a[W-1], b[W-1]}));
            end
            if (done) begin
                got = 1'b1;
                chk("done_cycle", 32'(c), 32'(exp_nb + 1));
                chk("result", 32'({gt, eq, lt, err}), 32'(exp_res));
                chk("nbits", 32'(nbits), 32'(exp_nb));
                break;
            end
            if (c == inj_cyc) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = '0;
            end
            if (c == force_cyc) begin
                force_val = 3'b101;
                force_en  = 1'b1;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        res_seen = {gt, eq, lt, err};
        nb_seen  = nbits;
        @(negedge clk);
        chk("idle_after", 32'({busy, done}), 32'd0);
        chk("held", 32'({gt, eq, lt, err, nbits}), 32'({res_seen, nb_seen}));
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        force_en  = 1'b0;
        force_val = 3'b000;
        #2;
        chk("reset_outs", 32'({busy, done, gt, eq, lt, err, bit_a, bit_b, nbits}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", 32'({busy, done, gt, eq, lt, err, nbits}), 32'd0);

        run_op(8'hA5, 8'hA5, 0, 0);
        run_op(8'h80, 8'h7F, 0, 0);
        run_op(8'h12, 8'h13, 0, 0);
        run_op(8'h00, 8'h00, 3, 0);
        run_op(8'hFF, 8'h00, 0, 0);
        run_op(8'hF0, 8'hF0, 0, 2);
        run_op(8'h01, 8'h80, 0, 0);

        // Reset in the middle of a compare aborts it.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h55;
        b_in  = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 32'({busy, done, gt, eq, lt, err, bit_a, bit_b, nbits}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("no_done_rst", 32'({done, busy}), 32'd0);
        end
        rst_n = 1'b1;
        run_op(8'h55, 8'h55, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            case ($urandom_range(2, 0))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
            endcase
            run_op(ra, rb, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
